// File: rtl/register_file.sv
// rtl/register_file.sv - multi-port register file with optional zero register, write bypass and written-register count
// Two combinational read ports, one synchronous write port; reset is synchronous and active-low.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic [ADDR_WIDTH:0]   wr_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_MAX =
    (ZERO_REG != 0) ? (ADDR_WIDTH+1)'(DEPTH - 1) : (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]      r_written;
  logic [ADDR_WIDTH:0]   r_wr_count;

  logic w_waddr_zero;
  logic w_wr_accept;
  logic w_fwd_ok;

  assign w_waddr_zero = (ZERO_REG != 0) && (waddr == '0);
  assign w_wr_accept  = we && !w_waddr_zero;
  // Forwarding is only meaningful when the write will actually land at the edge.
  assign w_fwd_ok     = (BYPASS != 0) && reset && w_wr_accept;

  function automatic logic [DATA_WIDTH-1:0] f_read(input logic [ADDR_WIDTH-1:0] addr);
    if ((ZERO_REG != 0) && (addr == '0))
      return '0;
    else if (w_fwd_ok && (addr == waddr))
      return wdata;
    else
      return r_mem[addr];
  endfunction

  always_comb begin
    rdata_a = f_read(raddr_a);
    rdata_b = f_read(raddr_b);
  end

  assign wr_count = r_wr_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
      r_written  <= '0;
      r_wr_count <= '0;
    end else begin
      if (we)
        assert (!$isunknown({waddr, wdata}));
      if (w_wr_accept) begin
        r_mem[waddr] <= wdata;
        if (!r_written[waddr]) begin
          r_written[waddr] <= 1'b1;
          if (r_wr_count != CNT_MAX)
            r_wr_count <= r_wr_count + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - scoreboard bench for register_file (default and no-bypass builds)
module tb_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr_a;
  logic [4:0]  raddr_b;
  logic [31:0] rdata_a, rdata_b, nb_rdata_a, nb_rdata_b;
  logic [5:0]  wr_count, nb_wr_count;

  always #5 clk = ~clk;

  register_file dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .wr_count(wr_count)
  );

  register_file #(.BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(nb_rdata_a), .rdata_b(nb_rdata_b), .wr_count(nb_wr_count)
  );

  typedef enum int { S_RA, S_RB, S_CNT, S_NB_RA, S_NB_CNT } sel_t;
  typedef struct {
    string       name;
    sel_t        sel;
    logic [31:0] exp;
  } chk_t;

  chk_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Monitor: compares every pending expectation against the outputs at the falling edge.
  initial begin
    chk_t        c;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        c = q.pop_front();
        case (c.sel)
          S_RA:     act = rdata_a;
          S_RB:     act = rdata_b;
          S_CNT:    act = {26'd0, wr_count};
          S_NB_RA:  act = nb_rdata_a;
          default:  act = {26'd0, nb_wr_count};
        endcase
        n_tests++;
        if (act !== c.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
        end
      end
    end
  end

  task automatic expect_val(input string name, input sel_t sel, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = exp;
    q.push_back(c);
  endtask

  task automatic drain;
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d checks pending, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb);
    we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    step;
    step;
    reset = 1'b1;

    // All addresses read zero after reset.
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 5'd0, 32'd0, 5'(a), 5'(31 - a));
      expect_val("reset_rd_a", S_RA, 32'd0);
      expect_val("reset_rd_b", S_RB, 32'd0);
      expect_val("reset_cnt", S_CNT, 32'd0);
      drain;
      step;
    end

    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2);
    step;
    drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
    expect_val("wr5_a", S_RA, 32'hDEADBEEF);
    expect_val("wr5_b", S_RB, 32'hDEADBEEF);
    expect_val("wr5_cnt", S_CNT, 32'd1);
    expect_val("wr5_nb_cnt", S_NB_CNT, 32'd1);
    drain;
    step;

    // Address 0 is hard-wired zero, even while being written.
    drive(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
    expect_val("zero_bypass_a", S_RA, 32'd0);
    drain;
    step;
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    expect_val("zero_rd_a", S_RA, 32'd0);
    expect_val("zero_rd_b", S_RB, 32'd0);
    expect_val("zero_cnt", S_CNT, 32'd1);
    drain;
    step;

    drive(1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd5);
    expect_val("bypass_a", S_RA, 32'hA5A5A5A5);
    expect_val("bypass_b_other", S_RB, 32'hDEADBEEF);
    expect_val("nobypass_a", S_NB_RA, 32'd0);
    drain;
    step;
    drive(1'b0, 5'd0, 32'd0, 5'd7, 5'd7);
    expect_val("post7_a", S_RA, 32'hA5A5A5A5);
    expect_val("post7_nb_a", S_NB_RA, 32'hA5A5A5A5);
    expect_val("post7_cnt", S_CNT, 32'd2);
    drain;
    step;

    // Fill 1..31 twice: count saturates at 31 and rewrites do not count.
    for (int a = 1; a < 32; a++) begin
      drive(1'b1, 5'(a), 32'hA000_0000 | 32'(a), 5'd0, 5'd0);
      step;
    end
    drive(1'b0, 5'd0, 32'd0, 5'd9, 5'd31);
    expect_val("fill1_cnt", S_CNT, 32'd31);
    expect_val("fill1_a", S_RA, 32'hA000_0009);
    expect_val("fill1_b", S_RB, 32'hA000_001F);
    drain;
    step;
    for (int a = 1; a < 32; a++) begin
      drive(1'b1, 5'(a), 32'hB000_0000 | 32'(a), 5'd0, 5'd0);
      step;
    end
    drive(1'b1, 5'd0, 32'h12345678, 5'd3, 5'd1);
    expect_val("fill2_cnt", S_CNT, 32'd31);
    expect_val("fill2_nb_cnt", S_NB_CNT, 32'd31);
    expect_val("fill2_a", S_RA, 32'hB000_0003);
    expect_val("fill2_b", S_RB, 32'hB000_0001);
    drain;
    step;
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd31);
    expect_val("sat_cnt", S_CNT, 32'd31);
    expect_val("sat_zero_a", S_RA, 32'd0);
    drain;
    step;

    // Reset coincident with a write: reset wins and bypass is suppressed.
    reset = 1'b0;
    drive(1'b1, 5'd3, 32'hFFFFFFFF, 5'd3, 5'd3);
    expect_val("rstwr_nobypass_a", S_RA, 32'hB000_0003);
    expect_val("rstwr_nb_a", S_NB_RA, 32'hB000_0003);
    drain;
    step;
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 5'd3, 5'd9);
    expect_val("rstwr_a", S_RA, 32'd0);
    expect_val("rstwr_b", S_RB, 32'd0);
    expect_val("rstwr_cnt", S_CNT, 32'd0);
    expect_val("rstwr_nb_cnt", S_NB_CNT, 32'd0);
    drain;
    step;

    drive(1'b1, 5'd10, 32'hCAFEF00D, 5'd0, 5'd0);
    step;
    drive(1'b0, 5'd0, 32'd0, 5'd10, 5'd3);
    expect_val("after_rst_a", S_RA, 32'hCAFEF00D);
    expect_val("after_rst_b", S_RB, 32'd0);
    expect_val("after_rst_cnt", S_CNT, 32'd1);
    drain;
    step;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
